// File: rtl/hd_beat_int_seq.sv
// Beat generator, ST0 phase flag, STOP/START run control and multi-step
// interrupt entry sequencer for the HD-CPU hardwired controller.
// All state changes happen on the falling edge of T3.
module hd_beat_int_seq #(
    parameter int unsigned NBEAT     = 3,
    parameter int unsigned SW_W      = 3,
    parameter int unsigned FLAG_W    = 3,
    parameter int unsigned INT_STEPS = 5
) (
    input  logic              T3,
    input  logic              CLR,
    input  logic [SW_W-1:0]   SW,
    input  logic              SHORT,
    input  logic              LONG,
    input  logic              STOP,
    input  logic              START,
    input  logic              SST0,
    input  logic              CLRST0,
    input  logic              PULSE,
    input  logic              EI_SET,
    input  logic              EI_CLR,
    input  logic              IRET,
    output logic [NBEAT-1:0]  W,
    output logic              ST0,
    output logic              RUN,
    output logic              EI,
    output logic              INT_PEND,
    output logic              INTACK,
    output logic [FLAG_W-1:0] FLAG,
    output logic              CYC_END
);

    typedef enum logic [1:0] {
        B_W1 = 2'd0,
        B_W2 = 2'd1,
        B_W3 = 2'd2,
        B_W4 = 2'd3
    } beat_e;

    beat_e             beat_q, beat_d, beat_nxt_c;
    logic [NBEAT-1:0]  w_q, w_d;
    logic              st0_q, st0_d;
    logic              run_q, run_d;
    logic              ei_q, ei_d;
    logic              pend_q, pend_d;
    logic              ack_q, ack_d;
    logic [FLAG_W-1:0] flag_q, flag_d;
    logic [SW_W-1:0]   sw_q, sw_d;
    logic              pulse_q, pulse_d;

    logic              adv_c;
    logic              cyc_edge_c;
    logic              entry_c;
    logic              rise_c;

    // Beat that would follow the current one if the sequencer advances.
    always_comb begin
        beat_nxt_c = B_W1;
        case (beat_q)
            B_W1:    beat_nxt_c = SHORT ? B_W1 : B_W2;
            B_W2:    beat_nxt_c = (LONG && (NBEAT >= 32'd3)) ? B_W3 : B_W1;
            B_W3:    beat_nxt_c = (LONG && (NBEAT == 32'd4)) ? B_W4 : B_W1;
            default: beat_nxt_c = B_W1;
        endcase
    end

    assign CYC_END = (beat_nxt_c == B_W1);

    // A STOP edge freezes the beat, so it is not treated as a cycle end.
    assign adv_c      = run_q && !STOP;
    assign cyc_edge_c = adv_c && CYC_END;
    assign rise_c     = PULSE && !pulse_q;
    assign entry_c    = cyc_edge_c && (sw_q == '0) && st0_q && (flag_q == '0)
                        && pend_q && ei_q;

    // Next-state logic: mode change pre-empts all normal sequencing.
    always_comb begin
        beat_d  = beat_q;
        st0_d   = st0_q;
        run_d   = run_q;
        ei_d    = ei_q;
        pend_d  = pend_q;
        ack_d   = 1'b0;
        flag_d  = flag_q;
        sw_d    = sw_q;
        pulse_d = PULSE;

        if (SW != sw_q) begin
            beat_d = B_W1;
            st0_d  = 1'b0;
            flag_d = '0;
            run_d  = 1'b1;
            sw_d   = SW;
        end else begin
            if (adv_c) begin
                beat_d = beat_nxt_c;
            end

            if (run_q && STOP) begin
                run_d = 1'b0;
            end else if (!run_q && START) begin
                run_d = 1'b1;
            end

            if (cyc_edge_c) begin
                if (CLRST0) begin
                    st0_d = 1'b0;
                end else if (SST0) begin
                    st0_d = 1'b1;
                end
            end

            if (entry_c) begin
                flag_d = FLAG_W'(1);
            end else if (cyc_edge_c && (flag_q != '0)) begin
                flag_d = (flag_q == FLAG_W'(INT_STEPS)) ? '0 : flag_q + FLAG_W'(1);
            end

            if (entry_c) begin
                ei_d = 1'b0;
            end else if (EI_CLR) begin
                ei_d = 1'b0;
            end else if (EI_SET) begin
                ei_d = 1'b1;
            end else if (IRET && cyc_edge_c && (flag_q == '0)) begin
                ei_d = 1'b1;
            end

            // A new request on the entry edge survives the acknowledge.
            if (rise_c) begin
                pend_d = 1'b1;
            end else if (entry_c) begin
                pend_d = 1'b0;
            end

            ack_d = entry_c;
        end
    end

    assign w_d = NBEAT'(1) << beat_d;

    // State register, synchronous reset on the falling edge of T3.
    always_ff @(negedge T3) begin
        if (CLR) begin
            beat_q  <= B_W1;
            w_q     <= NBEAT'(1);
            st0_q   <= 1'b0;
            run_q   <= 1'b1;
            ei_q    <= 1'b1;
            pend_q  <= 1'b0;
            ack_q   <= 1'b0;
            flag_q  <= '0;
            sw_q    <= SW;
            pulse_q <= PULSE;
        end else begin
            beat_q  <= beat_d;
            w_q     <= w_d;
            st0_q   <= st0_d;
            run_q   <= run_d;
            ei_q    <= ei_d;
            pend_q  <= pend_d;
            ack_q   <= ack_d;
            flag_q  <= flag_d;
            sw_q    <= sw_d;
            pulse_q <= pulse_d;
        end
    end

    assign W        = w_q;
    assign ST0      = st0_q;
    assign RUN      = run_q;
    assign EI       = ei_q;
    assign INT_PEND = pend_q;
    assign INTACK   = ack_q;
    assign FLAG     = flag_q;

endmodule

// File: doc/hd_beat_int_seq.md
Name: hd_beat_int_seq

Overview:
- Parametrised timing and interrupt sequencer for the HD-CPU hardwired controller.
- Generates the one-hot beat vector W, with SHORT/LONG cycle shaping and beat counts of 2..4.
- Holds the ST0 console/fetch phase flag and implements STOP/START run control.
- Runs a multi-step interrupt entry sequence (FLAG 1..INT_STEPS) gated by EI. The decode logic consumes W, ST0 and FLAG.

Parameters:
- NBEAT, 3, number of beats per cycle; valid 2..4.
- SW_W, 3, width of the console mode switch.
- FLAG_W, 3, width of the interrupt step counter.
- INT_STEPS, 5, number of instruction cycles in the interrupt sequence; 1..2^FLAG_W-1.

Ports:
- T3  in  1  clock; all state changes on the falling edge.
- CLR  in  1  synchronous reset, active-high.
- SW  in  SW_W  console mode; 0 = execute.
- SHORT  in  1  end the cycle after W1.
- LONG  in  1  extend the cycle past W2 (and past W3 when NBEAT=4).
- STOP  in  1  halt the sequencer.
- START  in  1  resume after STOP.
- SST0  in  1  set ST0 at cycle end.
- CLRST0  in  1  clear ST0 at cycle end.
- PULSE  in  1  interrupt request (level input, edge-detected).
- EI_SET  in  1  enable interrupts.
- EI_CLR  in  1  disable interrupts.
- IRET  in  1  return from interrupt.
- W  out  NBEAT  one-hot beat; bit 0 = W1.
- ST0  out  1  phase flag.
- RUN  out  1  sequencer running.
- EI  out  1  interrupt enable.
- INT_PEND  out  1  latched interrupt request.
- INTACK  out  1  one-cycle pulse on interrupt entry.
- FLAG  out  FLAG_W  0 = normal; k = interrupt step k.
- CYC_END  out  1  combinational: the next beat is W1.

Behaviour:
- Reset (CLR=1 at an edge): W=W1, ST0=0, RUN=1, EI=1, INT_PEND=0, INTACK=0, FLAG=0; SW latch=SW; PULSE history=PULSE. CLR overrides all other inputs.
- Beat advance, only while RUN=1:
  - W1: SHORT → W1, else W2.
  - W2: LONG and NBEAT≥3 → W3, else W1.
  - W3: LONG and NBEAT=4 → W4, else W1.
  - W4 → W1.
  - CYC_END is computed from the same rules. "Cycle-end edge" means an edge with RUN=1 and CYC_END=1.
- Run control:
  - RUN=1 and STOP=1: RUN→0 at that edge and W does not advance on that edge. START is ignored while RUN=1.
  - RUN=0: W, ST0, FLAG and IRET handling are frozen.
  - START=1 while RUN=0: RUN→1 at that edge; W resumes advancing on the following edge.
  - PULSE latching and EI_SET/EI_CLR remain active while stopped.
- ST0: updates only on cycle-end edges. CLRST0 → 0, otherwise SST0 → 1, otherwise hold. CLRST0 has priority.
- Mode change (SW ≠ latch, RUN ignored):
  - At that edge: W=W1, ST0=0, FLAG=0, RUN=1, latch=SW.
  - EI and INT_PEND are kept; no other update happens that edge.
- Interrupt latch: a rising edge on PULSE (PULSE=1, history=0) sets INT_PEND regardless of EI.
- Interrupt entry: cycle-end edge with SW=0, ST0=1, FLAG=0, INT_PEND=1, EI=1.
  - At that edge: FLAG→1, EI→0, INT_PEND→0.
  - INTACK=1 for exactly the next cycle.
  - A PULSE rising edge on the entry edge re-sets INT_PEND (set wins over clear).
- Interrupt sequence: each cycle-end edge with FLAG≠0 increments FLAG. FLAG=INT_STEPS at a cycle-end edge → FLAG=0. No nested entry while FLAG≠0.
- EI control:
  - Interrupt entry forces EI=0.
  - Otherwise EI_CLR → 0; else EI_SET → 1; else IRET on a cycle-end edge with FLAG=0 → 1.
  - EI_CLR beats EI_SET on the same edge.
- No arithmetic wrap: FLAG never exceeds INT_STEPS.

Test Plan:
- Reset/beats: CLR 1 cycle; no SHORT/LONG for 4 edges → W=001,010,001,010. LONG held during W2 → 001,010,100,001. SHORT during W1 → W stays 001.
- Stop/start: STOP in W2 → RUN=0, W=010 held for 5 edges. START → RUN=1, W=010 on that edge, 001 on the next. START with RUN=1 has no effect.
- ST0: SST0 mid-cycle → ST0 stays 0 until the cycle-end edge, then 1. SST0+CLRST0 at a cycle end → ST0=0. SW 000→001 in W2 → W=001, ST0=0, EI unchanged.
- Interrupt entry (INT_STEPS=5, SW=0, ST0=1): PULSE 0→1 → INT_PEND=1. Next cycle end → FLAG=1, EI=0, INTACK high one cycle. After 5 more cycle ends → FLAG=2,3,4,5,0.
- Masking: EI_CLR, then PULSE edge → INT_PEND=1, FLAG stays 0. EI_SET → entry at the next cycle end. IRET at a cycle end with FLAG=0 and EI=0 → EI=1.
- Reset mid-sequence: CLR while FLAG=3, RUN=0, INT_PEND=1 → all outputs at reset values on that edge. NBEAT=4 build with LONG held → W cycles 0001,0010,0100,1000,0001.
